// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the front-end pipeline hazard sequencer
// and the pipeline registers it controls.
package pipe_ctrl_pkg;

  localparam int REG_W = 5;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    STALL = 2'd2
  } hz_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-low reset; holds at all-ones.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_r;

  // Count up on inc, stop at the maximum value instead of wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {W{1'b0}};
    end else if (inc && (count_r != {W{1'b1}})) begin
      count_r <= count_r + {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the fetch->decode and decode->execute registers:
// redirects open flush windows, load-use hazards open stall windows.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES      = 3,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 32,
  parameter int REG_W             = pipe_ctrl_pkg::REG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             jal_ex,
  input  logic             jalr_ex,
  input  logic             branch_taken_ex,
  input  logic             load_ex,
  input  logic [REG_W-1:0] load_rd_ex,
  input  logic [REG_W-1:0] rs1_id,
  input  logic [REG_W-1:0] rs2_id,
  input  logic             rs1_used_id,
  input  logic             rs2_used_id,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [2:0] STALL_RELOAD = 3'(LOAD_STALL_CYCLES - 1);

  hz_state_e  state_r, state_next_s;
  logic [2:0] cnt_r, cnt_next_s;
  logic       redirect_s;
  logic       hazard_s;
  logic       flush_inc_s;

  assign redirect_s = jal_ex | jalr_ex | branch_taken_ex;
  assign hazard_s   = load_ex & (load_rd_ex != {REG_W{1'b0}}) &
                      ((rs1_used_id & (rs1_id == load_rd_ex)) |
                       (rs2_used_id & (rs2_id == load_rd_ex)));

  // State and window counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= RUN;
      cnt_r   <= 3'd0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
    end
  end

  // Next state and combinational controls; everything is forced low during reset
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    busy         = 1'b0;
    flush_inc_s  = 1'b0;
    if (!rst_n) begin
      state_next_s = RUN;
      cnt_next_s   = 3'd0;
    end else if (redirect_s) begin
      // A redirect overrides any stall and restarts the flush window
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      flush_inc_s = 1'b1;
      busy        = (state_r != RUN);
      if (FLUSH_CYCLES > 1) begin
        state_next_s = FLUSH;
        cnt_next_s   = FLUSH_RELOAD;
      end else begin
        state_next_s = RUN;
        cnt_next_s   = 3'd0;
      end
    end else begin
      busy = (state_r != RUN);
      case (state_r)
        FLUSH: begin
          if_id_flush = 1'b1;
          if (cnt_r <= 3'd1) begin
            state_next_s = RUN;
            cnt_next_s   = 3'd0;
          end else begin
            cnt_next_s = cnt_r - 3'd1;
          end
        end
        STALL: begin
          // A hazard seen here does not extend the current window
          pc_stall    = 1'b1;
          if_id_stall = 1'b1;
          id_ex_flush = 1'b1;
          if (cnt_r <= 3'd1) begin
            state_next_s = RUN;
            cnt_next_s   = 3'd0;
          end else begin
            cnt_next_s = cnt_r - 3'd1;
          end
        end
        RUN: begin
          if (hazard_s) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
              state_next_s = STALL;
              cnt_next_s   = STALL_RELOAD;
            end else begin
              state_next_s = RUN;
              cnt_next_s   = 3'd0;
            end
          end else begin
            state_next_s = RUN;
            cnt_next_s   = 3'd0;
          end
        end
        default: begin
          state_next_s = RUN;
          cnt_next_s   = 3'd0;
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (pc_stall),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_inc_s),
    .count (flush_cnt)
  );

endmodule
